// File: rtl/fost_dump_pkg.sv
// Shared types and constants for the post-halt state dump engine.
package fost_dump_pkg;

    // Dump sequencer states: memory words go through request/wait/output,
    // register words through request/output (register reads are same-cycle).
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MEM_REQ  = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_MEM_OUT  = 3'd3,
        S_REG_REQ  = 3'd4,
        S_REG_OUT  = 3'd5,
        S_DONE     = 3'd6
    } dump_state_t;

    // Tag carried with every dumped word.
    localparam logic KIND_MEM = 1'b0;
    localparam logic KIND_REG = 1'b1;

    // Larger of two integers, used to size the shared word counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/falling_edge_det.sv
// Registers a level and emits a one-cycle pulse when it goes from high to low.
module falling_edge_det (
    input  logic CLK,
    input  logic rst,
    input  logic sig,
    output logic fall
);

    logic sig_q;

    // Previous sample; resets high so a line already low at release counts as a fall.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig;
        end
    end

    assign fall = sig_q & ~sig;

endmodule

// File: rtl/halt_state_dump.sv
// Post-halt dump engine: on a falling halt line it streams a window of data
// memory followed by the whole register file over a valid/ready channel.
module halt_state_dump
    import fost_dump_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MEM_ADDR_W = 8,
    parameter int MEM_N      = 16,
    parameter int REG_N      = 8,
    parameter int REG_IDX_W  = $clog2(REG_N)
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  do_halt,
    input  logic [MEM_ADDR_W-1:0] dump_base,
    output logic                  mem_rd_en,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [REG_IDX_W-1:0]  reg_idx,
    input  logic [DATA_W-1:0]     reg_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_kind,
    output logic [MEM_ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0]     out_data,
    output logic                  busy,
    output logic                  done
);

    // One counter walks both the memory window and the register file, so it
    // must hold the larger of the two index ranges.
    localparam int CNT_W = max_int(MEM_ADDR_W, REG_IDX_W);

    if (MEM_N < 1) begin : g_bad_mem_n
        $error("halt_state_dump: MEM_N must be at least 1");
    end
    if (REG_N < 1) begin : g_bad_reg_n
        $error("halt_state_dump: REG_N must be at least 1");
    end
    if (MEM_N > (1 << MEM_ADDR_W)) begin : g_bad_mem_window
        $error("halt_state_dump: MEM_N exceeds the addressable memory");
    end

    dump_state_t           state;
    dump_state_t           state_nx;
    logic [CNT_W-1:0]      cnt;
    logic [MEM_ADDR_W-1:0] base_q;
    logic                  start;
    logic                  last_mem;
    logic                  last_reg;
    logic                  accept;

    falling_edge_det u_halt_edge (
        .CLK  (CLK),
        .rst  (rst),
        .sig  (do_halt),
        .fall (start)
    );

    assign last_mem = (cnt == CNT_W'(MEM_N - 1));
    assign last_reg = (cnt == CNT_W'(REG_N - 1));
    assign accept   = out_valid & out_ready;

    // Next-state selection; a start pulse outside IDLE is deliberately ignored.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:     if (start) state_nx = S_MEM_REQ;
            S_MEM_REQ:  state_nx = S_MEM_WAIT;
            S_MEM_WAIT: state_nx = S_MEM_OUT;
            S_MEM_OUT:  if (out_ready) state_nx = last_mem ? S_REG_REQ : S_MEM_REQ;
            S_REG_REQ:  state_nx = S_REG_OUT;
            S_REG_OUT:  if (out_ready) state_nx = last_reg ? S_DONE : S_REG_REQ;
            S_DONE:     if (do_halt) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // State register; reset abandons any partial dump.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Word counter: cleared at start and between the memory and register phases.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) cnt <= '0;
                end
                S_MEM_OUT: begin
                    if (accept) cnt <= last_mem ? '0 : cnt + CNT_W'(1);
                end
                S_REG_OUT: begin
                    if (accept) cnt <= last_reg ? '0 : cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Window base is captured once per dump so the caller may change it afterwards.
    always_ff @(posedge CLK) begin
        if (state == S_IDLE && start) begin
            base_q <= dump_base;
        end
    end

    // Output word holding register; only loaded outside the OUT states, so it
    // stays stable for as long as the consumer stalls.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_kind  <= KIND_MEM;
            out_index <= '0;
        end else if (state == S_MEM_WAIT) begin
            out_data  <= mem_rdata;
            out_kind  <= KIND_MEM;
            out_index <= MEM_ADDR_W'(cnt);
        end else if (state == S_REG_REQ) begin
            out_data  <= reg_rdata;
            out_kind  <= KIND_REG;
            out_index <= MEM_ADDR_W'(cnt);
        end
    end

    // Read strobes and status decode straight from state; the address adder
    // wraps modulo the memory size by construction.
    always_comb begin
        mem_rd_en = (state == S_MEM_REQ);
        mem_addr  = '0;
        reg_idx   = '0;
        if (state == S_MEM_REQ) begin
            mem_addr = base_q + MEM_ADDR_W'(cnt);
        end
        if (state == S_REG_REQ) begin
            reg_idx = REG_IDX_W'(cnt);
        end
        out_valid = (state == S_MEM_OUT) || (state == S_REG_OUT);
        busy      = (state != S_IDLE) && (state != S_DONE);
        done      = (state == S_DONE);
    end

endmodule

// File: tb/tb_halt_state_dump.sv
// Self-checking bench for halt_state_dump: behavioural memory and register
// file, expected word stream built from the window/register rules.
module tb_halt_state_dump;

    localparam int DATA_W     = 16;
    localparam int MEM_ADDR_W = 8;
    localparam int MEM_N      = 5;
    localparam int REG_N      = 8;
    localparam int REG_IDX_W  = 3;
    localparam int MEM_SIZE   = 1 << MEM_ADDR_W;

    logic                  CLK = 1'b0;
    logic                  rst = 1'b0;
    logic                  do_halt = 1'b1;
    logic [MEM_ADDR_W-1:0] dump_base = '0;
    logic                  mem_rd_en;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_rdata = '0;
    logic [REG_IDX_W-1:0]  reg_idx;
    logic [DATA_W-1:0]     reg_rdata;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic                  out_kind;
    logic [MEM_ADDR_W-1:0] out_index;
    logic [DATA_W-1:0]     out_data;
    logic                  busy;
    logic                  done;

    logic [DATA_W-1:0]     mem  [0:MEM_SIZE-1];
    logic [DATA_W-1:0]     regs [0:REG_N-1];
    logic [MEM_ADDR_W-1:0] addr_log[$];

    int vecs = 0;
    int miscompares = 0;

    halt_state_dump #(
        .DATA_W     (DATA_W),
        .MEM_ADDR_W (MEM_ADDR_W),
        .MEM_N      (MEM_N),
        .REG_N      (REG_N),
        .REG_IDX_W  (REG_IDX_W)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .do_halt   (do_halt),
        .dump_base (dump_base),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .reg_idx   (reg_idx),
        .reg_rdata (reg_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kind  (out_kind),
        .out_index (out_index),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read data memory with one cycle of latency; logs every read address.
    always @(posedge CLK) begin
        if (mem_rd_en === 1'b1) begin
            mem_rdata <= mem[mem_addr];
            addr_log.push_back(mem_addr);
        end
    end

    assign reg_rdata = regs[reg_idx];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_mem_rd_en"}, 32'(mem_rd_en), 0);
        chk({pfx, "_mem_addr"},  32'(mem_addr),  0);
        chk({pfx, "_reg_idx"},   32'(reg_idx),   0);
        chk({pfx, "_out_valid"}, 32'(out_valid), 0);
        chk({pfx, "_out_kind"},  32'(out_kind),  0);
        chk({pfx, "_out_index"}, 32'(out_index), 0);
        chk({pfx, "_out_data"},  32'(out_data),  0);
        chk({pfx, "_busy"},      32'(busy),      0);
        chk({pfx, "_done"},      32'(done),      0);
    endtask

    // Run one whole dump from the halt fall to DONE and check every word.
    task automatic run_dump(input logic [MEM_ADDR_W-1:0] base, input int stall_word,
                            input int stall_len, input bit rnd_ready, input bit toggle_halt);
        logic [DATA_W-1:0]     e_data[$];
        logic                  e_kind[$];
        int                    e_idx[$];
        int                    total;
        int                    got = 0;
        int                    cyc = 0;
        int                    stalled = 0;
        int                    first_vld = -1;
        int                    last_cyc = -1;
        bit                    prev_acc = 0;
        bit                    holding = 0;
        bit                    rdy;
        logic [DATA_W-1:0]     h_data = '0;
        logic                  h_kind = 1'b0;
        logic [MEM_ADDR_W-1:0] h_idx = '0;

        for (int i = 0; i < MEM_N; i++) begin
            e_kind.push_back(1'b0);
            e_idx.push_back(i);
            e_data.push_back(mem[(int'(base) + i) % MEM_SIZE]);
        end
        for (int r = 0; r < REG_N; r++) begin
            e_kind.push_back(1'b1);
            e_idx.push_back(r);
            e_data.push_back(regs[r]);
        end
        total = MEM_N + REG_N;
        addr_log.delete();

        @(negedge CLK);
        dump_base = base;
        do_halt   = 1'b0;
        out_ready = 1'b1;

        while (got < total && cyc < 1000) begin
            @(negedge CLK);
            cyc++;
            dump_base = MEM_ADDR_W'($urandom);
            if (toggle_halt) do_halt = 1'($urandom);
            if (cyc == 1) chk("start_rd_en", 32'(mem_rd_en), 1);
            chk("busy_during_dump", 32'(busy), 1);
            if (prev_acc) chk("gap_after_accept", 32'(out_valid), 0);
            prev_acc = 0;
            if (holding) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data",  32'(out_data),  32'(h_data));
                chk("hold_kind",  32'(out_kind),  32'(h_kind));
                chk("hold_index", 32'(out_index), 32'(h_idx));
            end
            if (out_valid === 1'b1) begin
                if (first_vld < 0) first_vld = cyc;
                if (got == stall_word && stalled < stall_len) begin
                    rdy = 1'b0;
                    stalled++;
                end else begin
                    rdy = rnd_ready ? 1'($urandom) : 1'b1;
                end
                out_ready = rdy;
                if (rdy) begin
                    chk("word_kind",  32'(out_kind),  32'(e_kind[got]));
                    chk("word_index", 32'(out_index), 32'(e_idx[got]));
                    chk("word_data",  32'(out_data),  32'(e_data[got]));
                    got++;
                    prev_acc = 1;
                    holding  = 0;
                    last_cyc = cyc;
                end else begin
                    holding = 1;
                    h_data  = out_data;
                    h_kind  = out_kind;
                    h_idx   = out_index;
                end
            end else begin
                holding   = 0;
                out_ready = rnd_ready ? 1'($urandom) : 1'b1;
            end
        end
        if (got < total) chk("dump_timeout_words", 32'(got), 32'(total));

        if (toggle_halt) do_halt = 1'b0;
        chk("first_valid_cycle", 32'(first_vld), 3);
        if (!rnd_ready) chk("dump_length", 32'(last_cyc), 32'(3 * MEM_N + 2 * REG_N + stall_len));

        @(negedge CLK);
        chk("done_after_last", 32'(done), 1);
        chk("busy_after_last", 32'(busy), 0);
        chk("valid_after_last", 32'(out_valid), 0);

        chk("addr_count", 32'(addr_log.size()), 32'(MEM_N));
        for (int i = 0; i < MEM_N && i < addr_log.size(); i++) begin
            chk("mem_addr_seq", 32'(addr_log[i]), 32'((int'(base) + i) % MEM_SIZE));
        end
    endtask

    // Raise the halt line after DONE and confirm the engine goes idle.
    task automatic release_halt();
        do_halt = 1'b1;
        @(negedge CLK);
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_rd_en", 32'(mem_rd_en), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = DATA_W'($urandom);
        for (int r = 0; r < REG_N; r++) regs[r] = DATA_W'($urandom);

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge CLK);
        chk("post_reset_busy", 32'(busy), 0);

        // Directed dump with the preset window and registers
        mem[10] = 16'd6; mem[11] = 16'd4; mem[12] = 16'd3; mem[13] = 16'd2; mem[14] = 16'd5;
        regs[1] = 16'd12; regs[2] = 16'd17; regs[3] = 16'd7;
        run_dump(8'd10, -1, 0, 1'b0, 1'b0);

        // done holds while halt stays low, then a rise returns to idle
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("done_held_low", 32'(done), 1);
        end
        release_halt();

        // Backpressure on word 2 for 7 cycles
        run_dump(8'd10, 2, 7, 1'b0, 1'b0);
        release_halt();

        // Address wrap past the top of memory, random consumer
        run_dump(8'd254, -1, 0, 1'b1, 1'b0);
        release_halt();

        // Halt line toggling while busy must not restart the dump
        run_dump(MEM_ADDR_W'($urandom), -1, 0, 1'b1, 1'b1);
        release_halt();

        // Reset in the middle of the third memory word
        @(negedge CLK);
        dump_base = 8'd20;
        do_halt   = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid === 1'b1 && out_index === 8'd2) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("reach_word2", 32'(out_index), 2);
        rst     = 1'b0;
        do_halt = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        chk("after_midreset_busy", 32'(busy), 0);
        chk("after_midreset_valid", 32'(out_valid), 0);
        run_dump(8'd20, -1, 0, 1'b0, 1'b0);
        release_halt();

        // A few more randomized dumps
        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < REG_N; r++) regs[r] = DATA_W'($urandom);
            run_dump(MEM_ADDR_W'($urandom), int'($urandom_range(0, MEM_N + REG_N - 1)),
                     int'($urandom_range(1, 4)), 1'b0, 1'b0);
            release_halt();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
